// File: rtl/spike_count_bank_if.sv
// Bundle between the output neuron layer / predictor and the spike-count bank.
// The slave modport is the bank itself; master is whoever feeds spikes and reads the counts.
interface spike_count_bank_if #(
    parameter int NUM_CLASSES = 10,
    parameter int COUNT_W     = 8
);
    logic                           start_i;
    logic                           spike_valid_i;
    logic [NUM_CLASSES-1:0]         spikes_i;
    logic                           busy_o;
    logic                           done_o;
    logic [NUM_CLASSES*COUNT_W-1:0] counts_o;
    logic [NUM_CLASSES-1:0]         sat_o;

    modport master (
        output start_i, spike_valid_i, spikes_i,
        input  busy_o, done_o, counts_o, sat_o
    );

    modport slave (
        input  start_i, spike_valid_i, spikes_i,
        output busy_o, done_o, counts_o, sat_o
    );
endinterface

// File: rtl/spike_count_bank.sv
// Per-class spike accumulator over a fixed window of WINDOW_LEN timesteps; latches the
// final counts and saturation flags and pulses done_o once per window.
module spike_count_bank #(
    parameter int NUM_CLASSES = 10,
    parameter int COUNT_W     = 8,
    parameter int WINDOW_LEN  = 255
) (
    input logic                clk_i,
    input logic                rst_ni,
    spike_count_bank_if.slave  bus
);
    localparam int STEP_W = $clog2(WINDOW_LEN + 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                         state;
    state_t                         state_next;
    logic [COUNT_W-1:0]             acc      [NUM_CLASSES];
    logic [COUNT_W-1:0]             acc_next [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]         sat;
    logic [NUM_CLASSES-1:0]         sat_next;
    logic [NUM_CLASSES*COUNT_W-1:0] acc_flat;
    logic [STEP_W-1:0]              step;
    logic                           take_step;
    logic                           last_step;
    logic [NUM_CLASSES*COUNT_W-1:0] counts;
    logic [NUM_CLASSES-1:0]         sat_out;
    logic                           done;

    assign take_step = (state == COUNT) && bus.spike_valid_i;
    assign last_step = (step == STEP_W'(WINDOW_LEN - 1));

    // A saturated counter holds its value and raises a sticky flag for the rest of the window.
    always_comb begin
        sat_next = sat;
        acc_flat = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            acc_next[k] = acc[k];
            if (bus.spikes_i[k]) begin
                if (acc[k] == CNT_MAX) begin
                    sat_next[k] = 1'b1;
                end else begin
                    acc_next[k] = acc[k] + COUNT_W'(1);
                end
            end
            acc_flat[k*COUNT_W +: COUNT_W] = acc_next[k];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_i) state_next = COUNT;
            COUNT:   if (take_step && last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc[k] <= '0;
            end
            sat     <= '0;
            step    <= '0;
            counts  <= '0;
            sat_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && bus.start_i) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    acc[k] <= '0;
                end
                sat  <= '0;
                step <= '0;
            end else if (take_step) begin
                acc  <= acc_next;
                sat  <= sat_next;
                step <= step + STEP_W'(1);
                // The final timestep's own spikes are folded into the published result.
                if (last_step) begin
                    counts  <= acc_flat;
                    sat_out <= sat_next;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = done;
    assign bus.counts_o = counts;
    assign bus.sat_o    = sat_out;
endmodule

// File: tb/tb_spike_count_bank.sv
// Directed bench for spike_count_bank: instance A (COUNT_W=8, WINDOW_LEN=4) for the counting
// and sequencing cases, instance B (COUNT_W=2, WINDOW_LEN=6) for saturation.
module tb_spike_count_bank;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [79:0] exp_a;

    always #5 clk_i = ~clk_i;

    spike_count_bank_if #(.NUM_CLASSES(10), .COUNT_W(8)) bus_a ();
    spike_count_bank_if #(.NUM_CLASSES(10), .COUNT_W(2)) bus_b ();

    spike_count_bank #(.NUM_CLASSES(10), .COUNT_W(8), .WINDOW_LEN(4)) dut_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_a)
    );

    spike_count_bank #(.NUM_CLASSES(10), .COUNT_W(2), .WINDOW_LEN(6)) dut_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic cycle_a(input logic start, input logic valid, input logic [9:0] spikes);
        @(negedge clk_i);
        bus_a.start_i       = start;
        bus_a.spike_valid_i = valid;
        bus_a.spikes_i      = spikes;
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle_b(input logic start, input logic valid, input logic [9:0] spikes);
        @(negedge clk_i);
        bus_b.start_i       = start;
        bus_b.spike_valid_i = valid;
        bus_b.spikes_i      = spikes;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bus_a.start_i = 1'b0; bus_a.spike_valid_i = 1'b0; bus_a.spikes_i = '0;
        bus_b.start_i = 1'b0; bus_b.spike_valid_i = 1'b0; bus_b.spikes_i = '0;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 128'(bus_a.busy_o), 128'(1'b0));
        check("rst_done", 128'(bus_a.done_o), 128'(1'b0));
        check("rst_counts", 128'(bus_a.counts_o), 128'(0));
        check("rst_sat", 128'(bus_a.sat_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic window: classes 0 and 3 spike on all four timesteps.
        cycle_a(1'b1, 1'b0, 10'b0);
        check("basic_busy", 128'(bus_a.busy_o), 128'(1'b1));
        cycle_a(1'b0, 1'b1, 10'b0000001001);
        cycle_a(1'b0, 1'b1, 10'b0000001001);
        cycle_a(1'b0, 1'b1, 10'b0000001001);
        check("basic_early_done", 128'(bus_a.done_o), 128'(1'b0));
        cycle_a(1'b0, 1'b1, 10'b0000001001);
        exp_a = '0; exp_a[0*8 +: 8] = 8'd4; exp_a[3*8 +: 8] = 8'd4;
        check("basic_done", 128'(bus_a.done_o), 128'(1'b1));
        check("basic_counts", 128'(bus_a.counts_o), 128'(exp_a));
        check("basic_sat", 128'(bus_a.sat_o), 128'(0));
        cycle_a(1'b0, 1'b0, 10'b0);
        check("basic_done_pulse", 128'(bus_a.done_o), 128'(1'b0));
        check("basic_idle", 128'(bus_a.busy_o), 128'(1'b0));
        check("basic_hold", 128'(bus_a.counts_o), 128'(exp_a));

        // Saturation on B: class5 every step (6 > 3), class2 exactly 3, class1 twice.
        cycle_b(1'b1, 1'b0, 10'b0);
        cycle_b(1'b0, 1'b1, 10'h026);
        cycle_b(1'b0, 1'b1, 10'h022);
        cycle_b(1'b0, 1'b1, 10'h024);
        cycle_b(1'b0, 1'b1, 10'h020);
        check("sat_not_yet_published", 128'(bus_b.sat_o), 128'(0));
        cycle_b(1'b0, 1'b1, 10'h024);
        check("sat_early_done", 128'(bus_b.done_o), 128'(1'b0));
        cycle_b(1'b0, 1'b1, 10'h020);
        check("sat_done", 128'(bus_b.done_o), 128'(1'b1));
        check("sat_counts", 128'(bus_b.counts_o), 128'(20'h00C38));
        check("sat_flags", 128'(bus_b.sat_o), 128'(10'b0000100000));
        cycle_b(1'b0, 1'b0, 10'b0);

        // Gaps: spikes in IDLE and on the start cycle must not be counted.
        cycle_a(1'b0, 1'b1, 10'h3FF);
        check("gap_idle_ignored", 128'(bus_a.busy_o), 128'(1'b0));
        cycle_a(1'b1, 1'b1, 10'h3FF);
        cycle_a(1'b0, 1'b1, 10'b0000000011);
        cycle_a(1'b0, 1'b0, 10'h3FF);
        cycle_a(1'b0, 1'b0, 10'h3FF);
        cycle_a(1'b0, 1'b1, 10'b0000000101);
        cycle_a(1'b0, 1'b1, 10'b1000000001);
        check("gap_stable_counts", 128'(bus_a.counts_o), 128'(exp_a));
        cycle_a(1'b0, 1'b0, 10'h3FF);
        cycle_a(1'b0, 1'b0, 10'h3FF);
        cycle_a(1'b0, 1'b0, 10'h3FF);
        check("gap_no_done", 128'(bus_a.done_o), 128'(1'b0));
        cycle_a(1'b0, 1'b1, 10'b0000000001);
        exp_a = '0; exp_a[0*8 +: 8] = 8'd4; exp_a[1*8 +: 8] = 8'd1;
        exp_a[2*8 +: 8] = 8'd1; exp_a[9*8 +: 8] = 8'd1;
        check("gap_done", 128'(bus_a.done_o), 128'(1'b1));
        check("gap_counts", 128'(bus_a.counts_o), 128'(exp_a));
        cycle_a(1'b0, 1'b0, 10'b0);

        // start_i pulses during COUNT and DONE must not restart the window.
        cycle_a(1'b1, 1'b0, 10'b0);
        cycle_a(1'b1, 1'b1, 10'b0000010000);
        cycle_a(1'b1, 1'b0, 10'b0);
        cycle_a(1'b0, 1'b1, 10'b0000010000);
        cycle_a(1'b1, 1'b1, 10'b0000010000);
        cycle_a(1'b0, 1'b1, 10'b0000010000);
        exp_a = '0; exp_a[4*8 +: 8] = 8'd4;
        check("ign_done", 128'(bus_a.done_o), 128'(1'b1));
        check("ign_counts", 128'(bus_a.counts_o), 128'(exp_a));
        cycle_a(1'b1, 1'b0, 10'b0);
        check("ign_done_start_busy", 128'(bus_a.busy_o), 128'(1'b0));
        cycle_a(1'b0, 1'b0, 10'b0);
        check("ign_stay_idle", 128'(bus_a.busy_o), 128'(1'b0));

        // Back-to-back: class7 window, then an all-zero window started right after DONE.
        cycle_a(1'b1, 1'b0, 10'b0);
        repeat (4) cycle_a(1'b0, 1'b1, 10'b0010000000);
        exp_a = '0; exp_a[7*8 +: 8] = 8'd4;
        check("b2b_first_done", 128'(bus_a.done_o), 128'(1'b1));
        check("b2b_first_counts", 128'(bus_a.counts_o), 128'(exp_a));
        cycle_a(1'b0, 1'b0, 10'b0);
        cycle_a(1'b1, 1'b0, 10'b0);
        check("b2b_restart_busy", 128'(bus_a.busy_o), 128'(1'b1));
        repeat (3) cycle_a(1'b0, 1'b1, 10'b0);
        check("b2b_hold_first", 128'(bus_a.counts_o), 128'(exp_a));
        cycle_a(1'b0, 1'b1, 10'b0);
        check("b2b_second_done", 128'(bus_a.done_o), 128'(1'b1));
        check("b2b_cleared", 128'(bus_a.counts_o), 128'(0));
        cycle_a(1'b0, 1'b0, 10'b0);

        // Asynchronous reset mid-window on both instances.
        @(negedge clk_i);
        bus_a.start_i = 1'b1;
        bus_b.start_i = 1'b1;
        @(posedge clk_i);
        #1;
        cycle_a(1'b0, 1'b1, 10'h3FF);
        cycle_a(1'b0, 1'b1, 10'h3FF);
        check("mid_busy_before_reset", 128'(bus_a.busy_o), 128'(1'b1));
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy", 128'(bus_a.busy_o), 128'(1'b0));
        check("mid_rst_done", 128'(bus_a.done_o), 128'(1'b0));
        check("mid_rst_counts", 128'(bus_b.counts_o), 128'(0));
        check("mid_rst_sat", 128'(bus_b.sat_o), 128'(0));
        check("mid_rst_busy_b", 128'(bus_b.busy_o), 128'(1'b0));
        bus_b.start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle_a(1'b0, 1'b1, 10'h3FF);
            check("post_rst_no_done", 128'(bus_a.done_o), 128'(1'b0));
        end
        check("post_rst_counts", 128'(bus_a.counts_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
